// File: rtl/display_scan.sv
// ---------------------------------------------------------------------------
// display_scan
//
// Time-multiplexed seven-segment scanner. Takes DIGITS packed seven-segment
// patterns and drives them one at a time onto a shared segment bus with a
// rotating one-hot digit enable. Each digit is shown for DIV clocks. The
// input patterns are captured once per frame (at slot 0, cycle 0) so a
// pattern never changes partway through a frame.
//
// Parameters:
//   DIGITS  number of digits scanned (width of dig_en)
//   DIV     clocks per digit slot, >= 2
//   BLANK   leading dark clocks per slot, 1 <= BLANK < DIV
//           (only used when DISPLAY_SCAN_BLANK_EN is defined)
//
// Build option:
//   DISPLAY_SCAN_BLANK_EN  when defined, the first BLANK clocks of every slot
//                          are dark to suppress ghosting between digits.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   scan enable, sampled on clk
//   seg_in       in   7*DIGITS packed patterns, digit i at [7i+6:7i]
//   seg_out      out  7-bit pattern of the selected digit (registered)
//   dig_en       out  one-hot digit select, all-zero when dark (registered)
//   frame_start  out  one-cycle pulse on the first cycle of slot 0
// ---------------------------------------------------------------------------
module display_scan #(
   parameter int DIGITS = 14,
   parameter int DIV    = 1000,
   parameter int BLANK  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [7*DIGITS-1:0]   seg_in,
   output logic [6:0]            seg_out,
   output logic [DIGITS-1:0]     dig_en,
   output logic                  frame_start
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [DIGITS-1:0] DIG_ONE = DIGITS'(1);

   // Reject parameter sets that cannot produce a valid slot.
   generate
      if (DIV < 2) begin : g_bad_div
         $error("display_scan: DIV must be >= 2");
      end
      if ((BLANK < 1) || (BLANK >= DIV)) begin : g_bad_blank
         $error("display_scan: BLANK must satisfy 1 <= BLANK < DIV");
      end
   endgenerate

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [7*DIGITS-1:0]   snap_q, snap_d;

   logic [6:0]            seg_out_q, seg_out_d;
   logic [DIGITS-1:0]     dig_en_q, dig_en_d;
   logic                  frame_start_q, frame_start_d;
   logic                  lit_s;

   // Scan sequencer: slot counter, digit index and per-frame snapshot.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      snap_d        = snap_q;
      frame_start_d = 1'b0;

      if (!en) begin
         // Abort immediately; the partial slot is discarded.
         state_d = ST_IDLE;
         idx_d   = {IDX_W{1'b0}};
         cnt_d   = {CNT_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d       = ST_SCAN;
               idx_d         = {IDX_W{1'b0}};
               cnt_d         = {CNT_W{1'b0}};
               snap_d        = seg_in;
               frame_start_d = 1'b1;
            end
            ST_SCAN: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d = {CNT_W{1'b0}};
                  if (idx_q == IDX_LAST) begin
                     // Frame wrap: the only point where new patterns are taken.
                     idx_d         = {IDX_W{1'b0}};
                     snap_d        = seg_in;
                     frame_start_d = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_ONE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               idx_d   = {IDX_W{1'b0}};
               cnt_d   = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Output decode from next state, so the registered outputs line up with
   // the state they describe (digit 0 lights right after the enabling edge).
   always_comb begin
      lit_s     = (state_d == ST_SCAN);
      dig_en_d  = {DIGITS{1'b0}};
      seg_out_d = 7'h00;
`ifdef DISPLAY_SCAN_BLANK_EN
      if (cnt_d < CNT_W'(BLANK)) begin
         lit_s = 1'b0;
      end else begin
         lit_s = (state_d == ST_SCAN);
      end
`endif
      if (lit_s) begin
         dig_en_d = DIG_ONE << idx_d;
         for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
               seg_out_d = snap_d[7*i +: 7];
            end else begin
               seg_out_d = seg_out_d;
            end
         end
      end else begin
         dig_en_d  = {DIGITS{1'b0}};
         seg_out_d = 7'h00;
      end
   end

   // State and output registers; reset forces everything dark.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         idx_q         <= {IDX_W{1'b0}};
         cnt_q         <= {CNT_W{1'b0}};
         snap_q        <= {(7*DIGITS){1'b0}};
         seg_out_q     <= 7'h00;
         dig_en_q      <= {DIGITS{1'b0}};
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         snap_q        <= snap_d;
         seg_out_q     <= seg_out_d;
         dig_en_q      <= dig_en_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign seg_out     = seg_out_q;
   assign dig_en      = dig_en_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan.sv
// ---------------------------------------------------------------------------
// tb_display_scan
//
// Self-checking bench for display_scan with DIGITS=14, DIV=4, BLANK=1.
// A frame-position model (time since frame start, snapshot array) predicts
// every output each cycle; directed sections pin the model with literal
// expectations, then randomized enable/pattern/reset traffic follows.
// ---------------------------------------------------------------------------
module tb_display_scan;

   localparam int DIGITS = 14;
   localparam int DIV    = 4;
   localparam int BLANK  = 1;
   localparam int FRAME  = DIGITS * DIV;
`ifdef DISPLAY_SCAN_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif

   logic                 clk    = 1'b0;
   logic                 rst_n  = 1'b0;
   logic                 en     = 1'b0;
   logic [7*DIGITS-1:0]  seg_in = '0;
   logic [6:0]           seg_out;
   logic [DIGITS-1:0]    dig_en;
   logic                 frame_start;

   always #5 clk = ~clk;

   display_scan #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .seg_in      (seg_in),
      .seg_out     (seg_out),
      .dig_en      (dig_en),
      .frame_start (frame_start)
   );

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: running flag, position within the frame, snapshot.
   bit                  m_run  = 1'b0;
   int                  m_t    = 0;
   logic [7*DIGITS-1:0] m_snap = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run  <= 1'b0;
         m_t    <= 0;
         m_snap <= '0;
      end else if (!en) begin
         m_run <= 1'b0;
         m_t   <= 0;
      end else if (!m_run) begin
         m_run  <= 1'b1;
         m_t    <= 0;
         m_snap <= seg_in;
      end else if (m_t == FRAME - 1) begin
         m_t    <= 0;
         m_snap <= seg_in;
      end else begin
         m_t <= m_t + 1;
      end
   end

   function automatic bit m_lit();
      if (!m_run) return 1'b0;
      if (BLANK_ON && ((m_t % DIV) < BLANK)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [DIGITS-1:0] m_dig();
      logic [DIGITS-1:0] one;
      one = 1;
      if (!m_lit()) return '0;
      return one << (m_t / DIV);
   endfunction

   function automatic logic [6:0] m_seg();
      if (!m_lit()) return 7'h00;
      return m_snap[7*(m_t / DIV) +: 7];
   endfunction

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_on) begin
         check("dig_en", 32'(dig_en), 32'(m_dig()));
         check("seg_out", 32'(seg_out), 32'(m_seg()));
         check("frame_start", 32'(frame_start), 32'(m_run && (m_t == 0)));
         check("onehot_max", 32'($countones(dig_en) <= 1), 32'd1);
`ifndef DISPLAY_SCAN_BLANK_EN
         if (m_run) check("onehot_lit", 32'($countones(dig_en)), 32'd1);
`endif
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [DIGITS-1:0] d0_lit;
      logic [6:0]        s0_lit;
      logic [DIGITS-1:0] d_full;
      d_full = '1;

      // Reset and idle.
      cycles(3);
      cmp_on = 1'b1;
      check("reset_dig", 32'(dig_en), 32'd0);
      check("reset_seg", 32'(seg_out), 32'd0);
      rst_n = 1'b1;
      cycles(3);

      // Basic scan: digit i shows i+1.
      for (int i = 0; i < DIGITS; i++) seg_in[7*i +: 7] = 7'(i + 1);
      en = 1'b1;
      cycles(1);                          // t = 0
      d0_lit = BLANK_ON ? 14'h0000 : 14'h0001;
      s0_lit = BLANK_ON ? 7'h00 : 7'h01;
      check("start_dig", 32'(dig_en), 32'(d0_lit));
      check("start_seg", 32'(seg_out), 32'(s0_lit));
      check("start_fs", 32'(frame_start), 32'd1);
      cycles(1);                          // t = 1, lit in both builds
      check("t1_dig", 32'(dig_en), 32'h0001);
      cycles(21);                         // t = 22, digit 5
      check("d5_dig", 32'(dig_en), 32'h0020);
      check("d5_seg", 32'(seg_out), 32'h06);
      check("d5_fs", 32'(frame_start), 32'd0);
      // Snapshot: change digit 0 while digit 5 shows.
      seg_in[6:0] = 7'h3F;
      cycles(33);                         // t = 55, digit 13
      check("d13_dig", 32'(dig_en), 32'h2000);
      check("d13_seg", 32'(seg_out), 32'h0E);
      check("d13_fs", 32'(frame_start), 32'd0);
      cycles(1);                          // t = 0 next frame, 56 after last pulse
      check("wrap_fs", 32'(frame_start), 32'd1);
      cycles(1);                          // t = 1
      check("wrap_dig", 32'(dig_en), 32'h0001);
      check("snap_seg", 32'(seg_out), 32'h3F);

      // Enable drop during digit 9 (t = 37).
      cycles(36);
      check("d9_dig", 32'(dig_en), 32'h0200);
      en = 1'b0;
      cycles(1);
      check("drop_dig", 32'(dig_en), 32'd0);
      check("drop_seg", 32'(seg_out), 32'd0);
      cycles(2);
      en = 1'b1;
      cycles(1);
      check("restart_fs", 32'(frame_start), 32'd1);
      check("restart_dig", 32'(dig_en), 32'(d0_lit));
      cycles(1);
      check("restart_seg", 32'(seg_out), 32'h3F);

      // Three full frames under the per-cycle one-hot checks.
      cycles(3 * FRAME);

      // Reset mid-scan: dark at once, then hold en low for 100 cycles.
      #1;
      rst_n = 1'b0;
      #1;
      check("async_dig", 32'(dig_en), 32'd0);
      check("async_seg", 32'(seg_out), 32'd0);
      check("async_fs", 32'(frame_start), 32'd0);
      en = 1'b0;
      cycles(2);
      rst_n = 1'b1;
      cycles(100);
      check("idle_dig", 32'(dig_en & d_full), 32'd0);

      // Randomized traffic checked against the model every cycle.
      en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 79) == 0) en = ~en;
         if ($urandom_range(0, 19) == 0) begin
            for (int i = 0; i < DIGITS; i++) seg_in[7*i +: 7] = 7'($urandom);
         end
         if ($urandom_range(0, 599) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            #2 rst_n = 1'b1;
         end
      end

      cycles(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
